// File: rtl/fb_arbiter.sv
// fb_arbiter: shares one single-port framebuffer RAM between display scan-out,
// a full-screen clear engine and a buffered pixel-write FIFO (in that priority).
module fb_arbiter #(
   parameter int H_RES      = 640,
   parameter int V_RES      = 480,
   parameter int ADDR_W     = 19,
   parameter int DATA_W     = 12,
   parameter int FIFO_DEPTH = 16
) (
   input  logic              pixelClk,
   input  logic              reset,
   input  logic              hVis,
   input  logic              vVis,
   input  logic [9:0]        xCor,
   input  logic [9:0]        yCor,
   output logic [DATA_W-1:0] pix_data,
   output logic              pix_valid,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              clr_start,
   input  logic [DATA_W-1:0] clr_color,
   output logic              clr_busy,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [15:0]       drop_cnt
);

   localparam int                PTR_W     = $clog2(FIFO_DEPTH);
   localparam logic [ADDR_W-1:0] NPIX      = ADDR_W'(H_RES * V_RES);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
   localparam logic [PTR_W:0]    PTR_ONE   = 1;
   localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;

   typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

   state_t            state, state_nxt;
   logic              vis_q, vis_q2;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] clr_cnt;
   logic [DATA_W-1:0] clr_color_q;
   logic [PTR_W:0]    wptr, rptr;
   logic [ADDR_W-1:0] f_addr [FIFO_DEPTH];
   logic [DATA_W-1:0] f_data [FIFO_DEPTH];
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data;
   logic              empty, full, push, pop, drop, clr_step;

   assign empty     = (wptr == rptr);
   assign full      = (wptr[PTR_W] != rptr[PTR_W]) &&
                      (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]);
   assign head_addr = f_addr[rptr[PTR_W-1:0]];
   assign head_data = f_data[rptr[PTR_W-1:0]];
   // gated by reset so every output reads 0 while reset is held
   assign wr_ready  = !reset && !full && (state == IDLE);
   assign push      = wr_valid && wr_ready;
   assign clr_busy  = (state != IDLE);

   // display pipeline: sample -> RAM read -> rdata capture -> pixel out
   always_ff @(posedge pixelClk or posedge reset) begin
      if (reset) begin
         vis_q     <= 1'b0;
         vis_q2    <= 1'b0;
         rd_addr   <= '0;
         pix_valid <= 1'b0;
         pix_data  <= '0;
      end else begin
         vis_q     <= hVis && vVis;
         vis_q2    <= vis_q;
         rd_addr   <= ADDR_W'(xCor) + ADDR_W'(H_RES) * ADDR_W'(yCor);
         pix_valid <= vis_q2;
         pix_data  <= vis_q2 ? mem_rdata : '0;
      end
   end

   always_ff @(posedge pixelClk) begin
      if (push) begin
         f_addr[wptr[PTR_W-1:0]] <= wr_addr;
         f_data[wptr[PTR_W-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge pixelClk or posedge reset) begin
      if (reset) begin
         wptr        <= '0;
         rptr        <= '0;
         clr_cnt     <= '0;
         clr_color_q <= '0;
         drop_cnt    <= '0;
      end else begin
         if (push) wptr <= wptr + PTR_ONE;
         if (pop)  rptr <= rptr + PTR_ONE;
         if (state == IDLE && clr_start) clr_color_q <= clr_color;
         if (clr_step) clr_cnt <= (clr_cnt == LAST_ADDR) ? '0 : clr_cnt + ADDR_ONE;
         if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
   end

   always_ff @(posedge pixelClk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // slot owner: display read, else clear write, else FIFO pop (drop if out of range)
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      pop       = 1'b0;
      drop      = 1'b0;
      clr_step  = 1'b0;
      state_nxt = state;
      if (vis_q) begin
         mem_en   = 1'b1;
         mem_addr = rd_addr;
      end else if (state == CLEAR) begin
         mem_en    = 1'b1;
         mem_we    = 1'b1;
         mem_addr  = clr_cnt;
         mem_wdata = clr_color_q;
         clr_step  = 1'b1;
      end else if (!empty) begin
         pop = 1'b1;
         if (head_addr >= NPIX) begin
            drop = 1'b1;
         end else begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = head_addr;
            mem_wdata = head_data;
         end
      end
      case (state)
         IDLE:    if (clr_start) state_nxt = empty ? CLEAR : DRAIN;
         DRAIN:   if (empty) state_nxt = CLEAR;
         CLEAR:   if (clr_step && clr_cnt == LAST_ADDR) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_fb_arbiter.sv
// Randomized bench for fb_arbiter against a queue-based slot/ownership model,
// with a small framebuffer geometry so full clears stay short.
module tb_fb_arbiter;

   localparam int H      = 16;
   localparam int V      = 8;
   localparam int NPIX   = H * V;
   localparam int DEPTH  = 16;
   localparam int AMAX   = (1 << 19) - 1;
   localparam int M_IDLE = 0, M_DRAIN = 1, M_CLEAR = 2;

   logic        pixelClk = 1'b0;
   logic        reset = 1'b1;
   logic        hVis = 1'b0, vVis = 1'b0;
   logic [9:0]  xCor = '0, yCor = '0;
   logic [11:0] pix_data;
   logic        pix_valid;
   logic        wr_valid = 1'b0;
   logic        wr_ready;
   logic [18:0] wr_addr = '0;
   logic [11:0] wr_data = '0;
   logic        clr_start = 1'b0;
   logic [11:0] clr_color = '0;
   logic        clr_busy;
   logic        mem_en, mem_we;
   logic [18:0] mem_addr;
   logic [11:0] mem_wdata;
   logic [11:0] mem_rdata = '0;
   logic [15:0] drop_cnt;

   fb_arbiter #(.H_RES(H), .V_RES(V), .ADDR_W(19), .DATA_W(12), .FIFO_DEPTH(DEPTH)) dut (
      .pixelClk(pixelClk), .reset(reset), .hVis(hVis), .vVis(vVis),
      .xCor(xCor), .yCor(yCor), .pix_data(pix_data), .pix_valid(pix_valid),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .drop_cnt(drop_cnt)
   );

   always #5 pixelClk = ~pixelClk;

   // framebuffer RAM seen by the DUT
   logic [11:0] env_ram [int];
   always @(posedge pixelClk) begin
      if (mem_en) begin
         if (mem_we) env_ram[int'(mem_addr)] = mem_wdata;
         else mem_rdata <= env_ram.exists(int'(mem_addr)) ? env_ram[int'(mem_addr)] : 12'h000;
      end
   end

   int n_checks = 0;
   int n_errs   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // reference model state
   int q_addr[$];
   int q_data[$];
   int model_ram [NPIX];
   int mode, clr_col, clr_next, drops;
   bit pv1;  int pa1;
   bit p2v;  int p2d;
   bit p3v;  int p3d;
   int obs_acc;

   function automatic void model_reset();
      q_addr.delete(); q_data.delete();
      mode = M_IDLE; clr_col = 0; clr_next = 0; drops = 0;
      pv1 = 0; pa1 = 0; p2v = 0; p2d = 0; p3v = 0; p3d = 0;
   endfunction

   function automatic int env_rd(input int a);
      return env_ram.exists(a) ? int'(env_ram[a]) : 0;
   endfunction

   task automatic step(input bit hv, input bit vv, input int x, input int y,
                       input bit wv, input int wa, input int wd, input bit cs, input int cc);
      int sz, m, a, d, rd_d;
      bit rd_v, e_rdy;
      hVis = hv; vVis = vv; xCor = 10'(x); yCor = 10'(y);
      wr_valid = wv; wr_addr = 19'(wa); wr_data = 12'(wd);
      clr_start = cs; clr_color = 12'(cc);
      @(negedge pixelClk);
      sz = q_addr.size(); m = mode;
      e_rdy = (sz < DEPTH) && (m == M_IDLE);
      check("wr_ready", wr_ready, e_rdy);
      check("clr_busy", clr_busy, m != M_IDLE);
      check("drop_cnt", drop_cnt, drops);
      check("pix_valid", pix_valid, p3v);
      check("pix_data", pix_data, p3d);
      if (wv && wr_ready) obs_acc++;
      rd_v = 0; rd_d = 0;
      if (pv1) begin
         check("rd_en", mem_en, 1);
         check("rd_we", mem_we, 0);
         check("rd_addr", mem_addr, pa1);
         rd_v = 1; rd_d = model_ram[pa1];
      end else if (m == M_CLEAR) begin
         check("clr_en", mem_en, 1);
         check("clr_we", mem_we, 1);
         check("clr_addr", mem_addr, clr_next);
         check("clr_wdata", mem_wdata, clr_col);
         model_ram[clr_next] = clr_col;
         clr_next++;
         if (clr_next == NPIX) begin clr_next = 0; mode = M_IDLE; end
      end else if (sz > 0) begin
         a = q_addr.pop_front(); d = q_data.pop_front();
         if (a >= NPIX) begin
            check("drop_en", mem_en, 0);
            if (drops < 65535) drops++;
         end else begin
            check("wr_en", mem_en, 1);
            check("wr_we", mem_we, 1);
            check("wr_addr", mem_addr, a);
            check("wr_wdata", mem_wdata, d);
            model_ram[a] = d;
         end
      end else begin
         check("idle_en", mem_en, 0);
      end
      if (m == M_IDLE && cs) begin
         clr_col = cc;
         mode = (sz > 0) ? M_DRAIN : M_CLEAR;
      end else if (m == M_DRAIN && sz == 0) begin
         mode = M_CLEAR;
      end
      if (wv && e_rdy) begin q_addr.push_back(wa); q_data.push_back(wd); end
      p3v = p2v; p3d = p2d;
      p2v = rd_v; p2d = rd_d;
      pv1 = hv && vv; pa1 = x + H * y;
      @(posedge pixelClk); #1;
   endtask

   task automatic blank(input int n);
      for (int i = 0; i < n; i++)
         step(0, $urandom_range(0, 1), $urandom_range(0, 1023), $urandom_range(0, 1023),
              0, 0, 0, 0, 0);
   endtask

   task automatic rnd_vis(output bit hv, output bit vv, output int x, output int y, input int pct);
      hv = ($urandom_range(0, 99) < pct); vv = hv || ($urandom_range(0, 1) == 1);
      x = $urandom_range(0, H - 1); y = $urandom_range(0, V - 1);
   endtask

   initial begin
      bit hv, vv;
      int x, y, budget;
      model_reset();
      obs_acc = 0;
      repeat (3) @(posedge pixelClk);
      #1 reset = 1'b0;

      // idle blanking after reset
      blank(5);

      // single write then read it back through the display path
      step(0, 0, 0, 0, 1, 20, 12'hF00, 0, 0);
      blank(2);
      step(1, 1, 4, 1, 0, 0, 0, 0, 0);
      blank(3);

      // burst of 20 writes during active video
      obs_acc = 0;
      for (int i = 0; i < 20; i++)
         step(1, 1, $urandom_range(0, H - 1), $urandom_range(0, V - 1),
              1, 40 + i, $urandom_range(0, 4095), 0, 0);
      check("burst_accepted", obs_acc, 16);
      check("burst_full_ready", wr_ready, 0);
      blank(20);
      for (int i = 0; i < 16; i++) check("burst_ram", env_rd(40 + i), model_ram[40 + i]);

      // out-of-range writes and drop counter saturation
      step(0, 0, 0, 0, 1, NPIX, 12'h123, 0, 0);
      blank(2);
      check("drop_one", drop_cnt, 1);
      for (int i = 0; i < 65540; i++)
         step(0, 0, 0, 0, 1, $urandom_range(NPIX, AMAX), $urandom_range(0, 4095), 0, 0);
      blank(3);
      check("drop_sat", drop_cnt, 16'hFFFF);

      // queued writes, then a clear that must drain them first
      for (int i = 0; i < 3; i++)
         step(1, 1, $urandom_range(0, H - 1), 0, 1, 100 + i, 12'h321 + i, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0, 1, 12'h0F0);
      check("drain_wr_ready", wr_ready, 0);
      budget = 5000;
      while (mode != M_IDLE && budget > 0) begin
         rnd_vis(hv, vv, x, y, 50);
         step(hv, vv, x, y, $urandom_range(0, 1), $urandom_range(0, NPIX - 1),
              $urandom_range(0, 4095), ($urandom_range(0, 19) == 0), $urandom_range(0, 4095));
         budget--;
      end
      check("clear_done_in_budget", budget > 0, 1);
      for (int i = 0; i < NPIX; i++) check("clear_ram", env_rd(i), 12'h0F0);

      // mixed random traffic
      for (int i = 0; i < 2000; i++) begin
         rnd_vis(hv, vv, x, y, 40);
         step(hv, vv, x, y, $urandom_range(0, 1),
              ($urandom_range(0, 9) == 0) ? $urandom_range(NPIX, AMAX) : $urandom_range(0, NPIX - 1),
              $urandom_range(0, 4095), ($urandom_range(0, 299) == 0), $urandom_range(0, 4095));
      end
      budget = 2000;
      while ((mode != M_IDLE || q_addr.size() != 0) && budget > 0) begin
         blank(1);
         budget--;
      end
      check("settle_in_budget", budget > 0, 1);

      // reset in the middle of a clear
      step(0, 0, 0, 0, 0, 0, 0, 1, 12'hABC);
      budget = 2000;
      while (clr_next < 50 && budget > 0) begin
         rnd_vis(hv, vv, x, y, 30);
         step(hv, vv, x, y, 0, 0, 0, 0, 0);
         budget--;
      end
      check("clear_progress_in_budget", budget > 0, 1);
      reset = 1'b1;
      #1;
      check("rst_pix_data", pix_data, 0);
      check("rst_pix_valid", pix_valid, 0);
      check("rst_mem_en", mem_en, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_clr_busy", clr_busy, 0);
      check("rst_drop_cnt", drop_cnt, 0);
      check("rst_wr_ready", wr_ready, 0);
      @(posedge pixelClk); #1;
      reset = 1'b0;
      model_reset();
      blank(4);
      for (int i = 0; i < 4; i++)
         step(0, 0, 0, 0, 1, 60 + i, 12'h555 + i, 0, 0);
      blank(4);

      for (int i = 0; i < NPIX; i++) check("ram_final", env_rd(i), model_ram[i]);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
      $finish;
   end

endmodule
